zxuno_regbus_arbiter: RTL
=========================

Name: zxuno_regbus_arbiter

Overview:
- Shares the ZX-UNO register bus (zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed) between the Z80 register ports and one internal master, such as a boot or OSD engine reading the core ID string.
- Sits between the CPU port decode and all register peripherals.
- Sequences the strobes so that stream-type registers behave identically for either master. Such registers reset their index on regaddr_changed and advance when the read strobe falls.
- CPU has priority. The internal master is served only when the bus is idle, and the CPU is stalled with wait while an internal transfer is in flight.

Parameters:
- HOLD_CYCLES, 2: cycles regrd/regwr are held for an internal transfer; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cpu_addr_we  in  1  one-cycle pulse: CPU wrote the register-address port
- cpu_data_we  in  1  one-cycle pulse: CPU wrote the register-data port
- cpu_data_re  in  1  level: CPU read cycle on the register-data port is active
- cpu_din  in  8  CPU write data (address or data)
- cpu_dout  out  8  read data to CPU
- cpu_wait_n  out  1  active-low wait to the Z80
- int_req  in  1  internal master request, level
- int_we  in  1  1 = write, 0 = read; stable while int_req is high
- int_addr  in  8  internal register address; stable while int_req is high
- int_wdata  in  8  internal write data; stable while int_req is high
- int_ack  out  1  one-cycle pulse: transfer complete
- int_rdata  out  8  captured read data; held until the next internal read
- zxuno_addr  out  8  register address to peripherals
- zxuno_regrd  out  1  register read strobe
- zxuno_regwr  out  1  register write strobe
- regaddr_changed  out  1  one-cycle address-change pulse
- bus_dout  out  8  write data to peripherals
- bus_din  in  8  wired read data from peripherals
- bus_oe_n  in  1  low = some peripheral drives bus_din

Behaviour:
- Reset state (asynchronous, active-high): state IDLE, cpu_addr_reg 0x00, both pending flags clear.
- Reset output values: zxuno_addr 0x00, all strobes 0, int_ack 0, int_rdata 0x00, cpu_wait_n 1, bus_dout 0x00.
- Reset mid-transfer aborts the transfer; no int_ack is issued.
- States: IDLE, INT_ADDR, INT_XFER, INT_DONE. All bus outputs are registered.

IDLE (CPU owns the bus):
- zxuno_addr = cpu_addr_reg.
- cpu_addr_we, or its pending flag: cpu_addr_reg <= cpu_din (or the latched value). regaddr_changed = 1 on the next cycle, for exactly 1 cycle, with zxuno_addr already showing the new value.
- cpu_data_we, or its pending flag: zxuno_regwr = 1 for 1 cycle with bus_dout = data.
- zxuno_regrd = cpu_data_re delayed 1 cycle.
- cpu_dout = bus_din when zxuno_regrd = 1 and bus_oe_n = 0, else 0xFF. This path is combinational.
- Priority: pending CPU pulse > new CPU pulse > int_req.
- int_req is accepted only if no CPU pulse is new or pending, cpu_data_re = 0, and zxuno_regrd = 0. Acceptance moves the state to INT_ADDR.
- An address pulse and a data-write pulse in the same cycle are serviced as address first, then write on the following cycle.

INT_ADDR (1 cycle):
- zxuno_addr = int_addr, regaddr_changed = 1 unconditionally.
- An internal access to a stream register therefore restarts that register's index; the same restart affects the CPU's stream.

INT_XFER (HOLD_CYCLES cycles, cycle counter):
- Read: zxuno_regrd = 1. Write: zxuno_regwr = 1, bus_dout = int_wdata.
- Last cycle of a read: int_rdata <= bus_oe_n ? 0xFF : bus_din.

INT_DONE (1 cycle):
- Strobes 0, which gives peripherals their falling edge.
- int_ack = 1.
- Next state IDLE. zxuno_addr returns to cpu_addr_reg without a regaddr_changed pulse.

Latency:
- int_ack rises 2 + HOLD_CYCLES cycles after the edge that sampled int_req in IDLE.
- The requester must drop int_req in the int_ack cycle, or a new transfer starts.

CPU during INT_*:
- cpu_addr_we and cpu_data_we set 1-deep pending flags with cpu_din latched; a second pulse of the same kind overwrites the first.
- cpu_wait_n = 0 while state != IDLE and (cpu_data_re = 1 or any pending flag is set).
- cpu_wait_n returns to 1 in the first IDLE cycle.
- No CPU strobe ever reaches the bus outside IDLE.

Test Plan:
1. CPU writes address 0xFF, then 14 read cycles (cpu_data_re high 3 cycles, low 2) -> regaddr_changed pulses once, one cycle after the write. cpu_dout sequence spells "PZXPlayer-V1.0"; a 15th read returns 0x00.
2. HOLD_CYCLES = 2, idle bus, int_req read of 0xFF -> regaddr_changed for 1 cycle, regrd for 2 cycles. int_ack 4 cycles after sampling; int_rdata = 0x50 ('P'). zxuno_addr then returns to cpu_addr_reg with no pulse.
3. cpu_data_re rises during INT_XFER -> cpu_wait_n = 0 until IDLE, then zxuno_regrd follows 1 cycle later. CPU receives correct data; int transfer is unaffected.
4. Same cycle: int_req (write 0x55 to 0x10) and cpu_data_we (0xAA, CPU address 0x20) -> regwr to 0x20 with 0xAA first, then the internal write to 0x10 with 0x55.
5. Internal read of an unmapped address (bus_oe_n stays 1) -> int_rdata = 0xFF, int_ack normal.
6. rst pulsed during INT_XFER -> all strobes 0 and zxuno_addr = 0x00 immediately, no int_ack. The next int_req completes normally.

Source files
------------

// File: rtl/zxuno_regbus_arbiter.sv
// rtl/zxuno_regbus_arbiter.sv - ZX-UNO register bus arbiter between Z80 ports and one internal master
// CPU owns the bus in IDLE; an internal transfer runs INT_ADDR -> INT_XFER -> INT_DONE.
module zxuno_regbus_arbiter #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_addr_we,
  input  logic       cpu_data_we,
  input  logic       cpu_data_re,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_wait_n,
  input  logic       int_req,
  input  logic       int_we,
  input  logic [7:0] int_addr,
  input  logic [7:0] int_wdata,
  output logic       int_ack,
  output logic [7:0] int_rdata,
  output logic [7:0] zxuno_addr,
  output logic       zxuno_regrd,
  output logic       zxuno_regwr,
  output logic       regaddr_changed,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  input  logic       bus_oe_n
);

  typedef enum logic [1:0] {IDLE, INT_ADDR, INT_XFER, INT_DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cpu_addr_reg, cpu_addr_reg_nxt;
  logic       addr_pend, addr_pend_nxt;
  logic [7:0] addr_pend_val, addr_pend_val_nxt;
  logic       data_pend, data_pend_nxt;
  logic [7:0] data_pend_val, data_pend_val_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;
  logic [7:0] zxuno_addr_nxt;
  logic       zxuno_regrd_nxt;
  logic       zxuno_regwr_nxt;
  logic       regaddr_changed_nxt;
  logic [7:0] bus_dout_nxt;
  logic       int_ack_nxt;
  logic [7:0] int_rdata_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    cpu_addr_reg_nxt    = cpu_addr_reg;
    addr_pend_nxt       = addr_pend;
    addr_pend_val_nxt   = addr_pend_val;
    data_pend_nxt       = data_pend;
    data_pend_val_nxt   = data_pend_val;
    hold_cnt_nxt        = hold_cnt;
    zxuno_addr_nxt      = zxuno_addr;
    zxuno_regrd_nxt     = 1'b0;
    zxuno_regwr_nxt     = 1'b0;
    regaddr_changed_nxt = 1'b0;
    bus_dout_nxt        = bus_dout;
    int_ack_nxt         = 1'b0;
    int_rdata_nxt       = int_rdata;

    case (state)
      IDLE: begin
        zxuno_addr_nxt  = cpu_addr_reg;
        zxuno_regrd_nxt = cpu_data_re;
        if (addr_pend || cpu_addr_we) begin
          cpu_addr_reg_nxt    = addr_pend ? addr_pend_val : cpu_din;
          zxuno_addr_nxt      = addr_pend ? addr_pend_val : cpu_din;
          regaddr_changed_nxt = 1'b1;
          if (addr_pend) begin
            addr_pend_nxt = cpu_addr_we;
            if (cpu_addr_we) addr_pend_val_nxt = cpu_din;
          end
          // A data write arriving alongside an address update goes out next cycle.
          if (cpu_data_we) begin
            data_pend_nxt     = 1'b1;
            data_pend_val_nxt = cpu_din;
          end
        end else if (data_pend || cpu_data_we) begin
          zxuno_regwr_nxt = 1'b1;
          bus_dout_nxt    = data_pend ? data_pend_val : cpu_din;
          if (data_pend) begin
            data_pend_nxt = cpu_data_we;
            if (cpu_data_we) data_pend_val_nxt = cpu_din;
          end
        end else if (int_req && !cpu_data_re && !zxuno_regrd) begin
          state_nxt = INT_ADDR;
        end
      end

      INT_ADDR: begin
        zxuno_addr_nxt      = int_addr;
        regaddr_changed_nxt = 1'b1;
        hold_cnt_nxt        = 4'd0;
        state_nxt           = INT_XFER;
      end

      INT_XFER: begin
        zxuno_regrd_nxt = !int_we;
        zxuno_regwr_nxt = int_we;
        if (int_we) bus_dout_nxt = int_wdata;
        if (hold_cnt == HOLD_LAST) state_nxt = INT_DONE;
        else                       hold_cnt_nxt = hold_cnt + 4'd1;
      end

      INT_DONE: begin
        // Address is held one more cycle so peripherals see the strobe fall on it.
        int_ack_nxt = 1'b1;
        if (!int_we) int_rdata_nxt = bus_oe_n ? 8'hFF : bus_din;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) begin
      if (cpu_addr_we) begin
        addr_pend_nxt     = 1'b1;
        addr_pend_val_nxt = cpu_din;
      end
      if (cpu_data_we) begin
        data_pend_nxt     = 1'b1;
        data_pend_val_nxt = cpu_din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_addr_reg    <= 8'h00;
      addr_pend       <= 1'b0;
      addr_pend_val   <= 8'h00;
      data_pend       <= 1'b0;
      data_pend_val   <= 8'h00;
      hold_cnt        <= 4'd0;
      zxuno_addr      <= 8'h00;
      zxuno_regrd     <= 1'b0;
      zxuno_regwr     <= 1'b0;
      regaddr_changed <= 1'b0;
      bus_dout        <= 8'h00;
      int_ack         <= 1'b0;
      int_rdata       <= 8'h00;
    end else begin
      cpu_addr_reg    <= cpu_addr_reg_nxt;
      addr_pend       <= addr_pend_nxt;
      addr_pend_val   <= addr_pend_val_nxt;
      data_pend       <= data_pend_nxt;
      data_pend_val   <= data_pend_val_nxt;
      hold_cnt        <= hold_cnt_nxt;
      zxuno_addr      <= zxuno_addr_nxt;
      zxuno_regrd     <= zxuno_regrd_nxt;
      zxuno_regwr     <= zxuno_regwr_nxt;
      regaddr_changed <= regaddr_changed_nxt;
      bus_dout        <= bus_dout_nxt;
      int_ack         <= int_ack_nxt;
      int_rdata       <= int_rdata_nxt;
    end
  end

  assign cpu_wait_n = !((state != IDLE) && (cpu_data_re || addr_pend || data_pend));
  assign cpu_dout   = (zxuno_regrd && !bus_oe_n) ? bus_din : 8'hFF;

endmodule
